// File: rtl/sprite_fetch_pipe.sv
// rtl/sprite_fetch_pipe.sv - three-stage sprite hit-test / RAM fetch / transparency pipeline
module sprite_fetch_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int N_FRAMES   = 4,
    parameter int FRAME_DIV  = 8,
    parameter logic [DATA_WIDTH-1:0] TRANSP   = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vsync_start,
    input  logic                  anim_en,
    input  logic                  pos_we,
    input  logic [9:0]            pos_x_i,
    input  logic [9:0]            pos_y_i,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  pixel_valid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] pix_o,
    output logic                  pix_hit_o,
    output logic                  pix_valid_o
);

    localparam int DIV_W       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FRM_W       = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int FRAME_WORDS = SPR_W * SPR_H;

    logic [9:0]       pend_x, pend_y;
    logic [9:0]       act_x, act_y;
    logic [DIV_W-1:0] div_cnt;
    logic [FRM_W-1:0] frame_idx;

    logic                  hit0;
    logic [10:0]           sx_end, sy_end;
    logic [9:0]            dx, dy;
    logic [ADDR_WIDTH-1:0] addr0;

    logic hit1, valid1;
    logic hit2, valid2;
    logic opaque;

    assign ram_we = 1'b0;

    // A write coinciding with vsync bypasses the pending register so it takes effect this frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_x <= '0;
            pend_y <= '0;
            act_x  <= '0;
            act_y  <= '0;
        end else begin
            if (pos_we) begin
                pend_x <= pos_x_i;
                pend_y <= pos_y_i;
            end
            if (vsync_start) begin
                if (pos_we) begin
                    act_x <= pos_x_i;
                    act_y <= pos_y_i;
                end else begin
                    act_x <= pend_x;
                    act_y <= pend_y;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            frame_idx <= '0;
        end else if (vsync_start && anim_en) begin
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt   <= '0;
                frame_idx <= (frame_idx == FRM_W'(N_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Bounds are formed at 11 bits so a sprite near x/y=1023 is clipped instead of wrapping to 0.
    assign sx_end = {1'b0, act_x} + 11'(SPR_W);
    assign sy_end = {1'b0, act_y} + 11'(SPR_H);

    assign hit0 = pixel_valid
                  && (pixel_x >= act_x) && ({1'b0, pixel_x} < sx_end)
                  && (pixel_y >= act_y) && ({1'b0, pixel_y} < sy_end);

    assign dx = pixel_x - act_x;
    assign dy = pixel_y - act_y;

    assign addr0 = ADDR_WIDTH'(frame_idx) * ADDR_WIDTH'(FRAME_WORDS)
                 + ADDR_WIDTH'(dy) * ADDR_WIDTH'(SPR_W)
                 + ADDR_WIDTH'(dx);

    assign opaque = hit2 && (ram_data != TRANSP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_en      <= 1'b0;
            ram_addr    <= '0;
            hit1        <= 1'b0;
            valid1      <= 1'b0;
            hit2        <= 1'b0;
            valid2      <= 1'b0;
            pix_o       <= '0;
            pix_hit_o   <= 1'b0;
            pix_valid_o <= 1'b0;
        end else begin
            ram_en      <= 1'b1;
            ram_addr    <= hit0 ? addr0 : '0;
            hit1        <= hit0;
            valid1      <= pixel_valid;
            hit2        <= hit1;
            valid2      <= valid1;
            pix_o       <= opaque ? ram_data : BG_COLOR;
            pix_hit_o   <= opaque;
            pix_valid_o <= valid2;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_pipe.sv
// tb/tb_sprite_fetch_pipe.sv - randomized self-checking bench for sprite_fetch_pipe
module tb_sprite_fetch_pipe;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int N_FRAMES = 4;
    localparam int FRAME_DIV = 8;
    localparam logic [7:0] TRANSP = 8'hFF;
    localparam logic [7:0] BG = 8'h00;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vsync_start = 1'b0;
    logic          anim_en = 1'b0;
    logic          pos_we = 1'b0;
    logic [9:0]    pos_x_i = '0;
    logic [9:0]    pos_y_i = '0;
    logic [9:0]    pixel_x = '0;
    logic [9:0]    pixel_y = '0;
    logic          pixel_valid = 1'b0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data = '0;
    logic [DW-1:0] pix_o;
    logic          pix_hit_o;
    logic          pix_valid_o;

    always #5 clk = ~clk;

    sprite_fetch_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .N_FRAMES(N_FRAMES), .FRAME_DIV(FRAME_DIV), .TRANSP(TRANSP), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vsync_start(vsync_start), .anim_en(anim_en),
        .pos_we(pos_we), .pos_x_i(pos_x_i), .pos_y_i(pos_y_i),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .pix_o(pix_o), .pix_hit_o(pix_hit_o), .pix_valid_o(pix_valid_o)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_data <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_fail = 0;

    int m_pend_x, m_pend_y, m_act_x, m_act_y, m_anim;
    logic [15:0] q_addr[$];
    logic [9:0]  q_out[$];

    function automatic int m_frame();
        return (m_anim / FRAME_DIV) % N_FRAMES;
    endfunction

    task automatic model_reset();
        m_pend_x = 0; m_pend_y = 0; m_act_x = 0; m_act_y = 0; m_anim = 0;
        q_addr.delete();
        q_out.delete();
        repeat (3) begin
            q_addr.push_front(16'h0);
            q_out.push_front({2'b00, BG});
        end
    endtask

    task automatic cyc(input logic vs, input logic ae, input logic pwe, input int nx, input int ny,
                       input logic pv, input int px, input int py);
        logic hit, opq;
        int addr;
        logic [7:0] col;
        vsync_start = vs; anim_en = ae; pos_we = pwe;
        pos_x_i = 10'(nx); pos_y_i = 10'(ny);
        pixel_valid = pv; pixel_x = 10'(px); pixel_y = 10'(py);
        hit = pv && px >= m_act_x && px < m_act_x + SPR_W && py >= m_act_y && py < m_act_y + SPR_H;
        addr = hit ? (m_frame() * SPR_W * SPR_H + (py - m_act_y) * SPR_W + (px - m_act_x)) % 65536 : 0;
        opq = hit && (mem[addr] != TRANSP);
        col = opq ? mem[addr] : BG;
        q_addr.push_front(16'(addr));
        q_out.push_front({pv, opq, col});
        if (q_addr.size() > 4) begin
            void'(q_addr.pop_back());
            void'(q_out.pop_back());
        end
        @(posedge clk);
        #1;
        if (pwe && vs) begin
            m_act_x = nx; m_act_y = ny; m_pend_x = nx; m_pend_y = ny;
        end else begin
            if (vs) begin m_act_x = m_pend_x; m_act_y = m_pend_y; end
            if (pwe) begin m_pend_x = nx; m_pend_y = ny; end
        end
        if (vs && ae) m_anim++;
        vsync_start = 1'b0; pos_we = 1'b0;
    endtask

    task automatic pix(input int px, input int py);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, px, py);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ram_en, ram_we, pix_hit_o, pix_valid_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0000", {ram_en, ram_we, pix_hit_o, pix_valid_o});
        end
        n_checks++;
        if ({ram_addr, pix_o} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h pix=%h want 0", ram_addr, pix_o);
        end
        reset_n = 1'b1;
        model_reset();
        idle();
        n_checks++;
        if (ram_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ram_en_after_release got %b want 1", ram_en);
        end
        idle(); idle();
    endtask

    task automatic test_read_path();
        mem[35] = 8'h5A;
        cyc(1'b1, 1'b0, 1'b1, 100, 50, 1'b0, 0, 0);
        pix(103, 52);
        n_checks++;
        if (ram_addr !== 16'd35 || ram_addr !== q_addr[0]) begin
            n_fail++;
            $display("FAIL read_addr got %0d want 35", ram_addr);
        end
        idle(); idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o, pix_o} !== {2'b11, 8'h5A}) begin
            n_fail++;
            $display("FAIL read_pix got v=%b h=%b p=%h want v=1 h=1 p=5a", pix_valid_o, pix_hit_o, pix_o);
        end
    endtask

    task automatic test_edges();
        int xs[5] = '{115, 116, 99, 100, 100};
        int ys[5] = '{65, 50, 50, 66, 50};
        int ea[5] = '{255, 0, 0, 0, 0};
        logic [9:0] eo[5];
        eo[0] = {2'b11, 8'h3C};
        for (int i = 1; i < 5; i++) eo[i] = {2'b10, 8'h00};
        mem[0] = 8'hFF;
        mem[255] = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) pix(xs[i], ys[i]); else idle();
            if (i < 5) begin
                n_checks++;
                if (ram_addr !== 16'(ea[i])) begin
                    n_fail++;
                    $display("FAIL edge_addr[%0d] got %0d want %0d", i, ram_addr, ea[i]);
                end
            end
            if (i >= 2) begin
                n_checks++;
                if ({pix_valid_o, pix_hit_o, pix_o} !== eo[i-2] || eo[i-2] !== q_out[2]) begin
                    n_fail++;
                    $display("FAIL edge_pix[%0d] got %h want %h", i - 2, {pix_valid_o, pix_hit_o, pix_o}, eo[i-2]);
                end
            end
        end
    endtask

    task automatic test_double_buffer();
        mem[0] = 8'h11;
        cyc(1'b0, 1'b0, 1'b1, 200, 10, 1'b1, 103, 52);
        n_checks++;
        if (ram_addr !== 16'd35) begin
            n_fail++;
            $display("FAIL dbuf_old_same_cycle got %0d want 35", ram_addr);
        end
        pix(103, 52);
        n_checks++;
        if (ram_addr !== 16'd35) begin
            n_fail++;
            $display("FAIL dbuf_old_pos got %0d want 35", ram_addr);
        end
        pix(200, 10);
        idle(); idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL dbuf_no_tear got v=%b h=%b want v=1 h=0", pix_valid_o, pix_hit_o);
        end
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        pix(200, 10);
        idle(); idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o, pix_o} !== {2'b11, 8'h11}) begin
            n_fail++;
            $display("FAIL dbuf_after_vsync got %h want 311", {pix_valid_o, pix_hit_o, pix_o});
        end
        cyc(1'b1, 1'b0, 1'b1, 300, 20, 1'b0, 0, 0);
        pix(300, 20);
        idle(); idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o, pix_o} !== {2'b11, 8'h11}) begin
            n_fail++;
            $display("FAIL dbuf_bypass got %h want 311", {pix_valid_o, pix_hit_o, pix_o});
        end
    endtask

    task automatic test_animation();
        int pulses[3] = '{8, 24, 16};
        logic en[3] = '{1'b1, 1'b1, 1'b0};
        int ea[3] = '{256, 0, 0};
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < pulses[s]; p++) cyc(1'b1, en[s], 1'b0, 0, 0, 1'b0, 0, 0);
            pix(300, 20);
            n_checks++;
            if (ram_addr !== 16'(ea[s]) || ram_addr !== q_addr[0]) begin
                n_fail++;
                $display("FAIL anim_step[%0d] got %0d want %0d", s, ram_addr, ea[s]);
            end
        end
        idle(); idle();
    endtask

    task automatic test_right_edge();
        mem[3] = 8'h33;
        cyc(1'b1, 1'b0, 1'b1, 1020, 0, 1'b0, 0, 0);
        pix(1023, 0);
        n_checks++;
        if (ram_addr !== 16'd3) begin
            n_fail++;
            $display("FAIL clamp_addr got %0d want 3", ram_addr);
        end
        pix(0, 0);
        idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o, pix_o} !== {2'b11, 8'h33}) begin
            n_fail++;
            $display("FAIL clamp_hit got %h want 333", {pix_valid_o, pix_hit_o, pix_o});
        end
        idle();
        n_checks++;
        if ({pix_valid_o, pix_hit_o, pix_o} !== {2'b10, 8'h00}) begin
            n_fail++;
            $display("FAIL clamp_nowrap got %h want 200", {pix_valid_o, pix_hit_o, pix_o});
        end
    endtask

    task automatic test_random();
        int px, py, nx, ny;
        for (int i = 0; i < 1024; i++) mem[i] = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            nx = int'($urandom_range(0, 1023));
            ny = int'($urandom_range(0, 1023));
            px = (m_act_x + int'($urandom_range(0, 21)) - 3 + 1024) % 1024;
            py = (m_act_y + int'($urandom_range(0, 21)) - 3 + 1024) % 1024;
            cyc($urandom % 12 == 0, 1'($urandom), $urandom % 10 == 0, nx, ny, $urandom % 8 != 0, px, py);
            n_checks++;
            if (ram_addr !== q_addr[0]) begin
                n_fail++;
                $display("FAIL rand_addr[%0d] got %0d want %0d", i, ram_addr, q_addr[0]);
            end
            n_checks++;
            if ({pix_valid_o, pix_hit_o, pix_o} !== q_out[2]) begin
                n_fail++;
                $display("FAIL rand_pix[%0d] got %h want %h", i, {pix_valid_o, pix_hit_o, pix_o}, q_out[2]);
            end
        end
        idle(); idle();
    endtask

    task automatic test_reset_midstream();
        for (int f = 0; f < N_FRAMES; f++)
            for (int i = 0; i < SPR_W; i++) mem[f * 256 + i] = 8'h40 + 8'(i);
        mem[1] = 8'h12;
        mem[2] = 8'h13;
        cyc(1'b1, 1'b0, 1'b1, 400, 100, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            pix(400 + i, 100);
            if (i >= 2) begin
                n_checks++;
                if ({pix_valid_o, pix_hit_o, pix_o} !== q_out[2]) begin
                    n_fail++;
                    $display("FAIL stream_pix[%0d] got %h want %h", i, {pix_valid_o, pix_hit_o, pix_o}, q_out[2]);
                end
            end
        end
        #3;
        reset_n = 1'b0;
        pixel_valid = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid_o, pix_hit_o, ram_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset got v=%b h=%b en=%b want 000", pix_valid_o, pix_hit_o, ram_en);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) pix(i, 0); else idle();
            n_checks++;
            if ({pix_valid_o, pix_hit_o, pix_o} !== q_out[2] || pix_valid_o !== (i >= 2)) begin
                n_fail++;
                $display("FAIL post_reset_pix[%0d] got %h want %h", i, {pix_valid_o, pix_hit_o, pix_o}, q_out[2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = ($urandom % 8 == 0) ? 8'hFF : 8'($urandom);
        model_reset();
        test_reset();
        test_read_path();
        test_edges();
        test_double_buffer();
        test_animation();
        test_right_edge();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
